// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-style read channel between ICache, DCache and uncached loads.
// One burst in flight; the grant is held from the AR issue until the last R beat.
//   state  | meaning
//   S_IDLE | pick the next requester from rr_ptr and latch its payload
//   S_ADDR | drive AR until arready
//   S_DATA | route R beats to the granted requester until rlast
module axi_rd_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_last,
    output logic                      arvalid,
    output logic [ADDR_W-1:0]         araddr,
    output logic [LEN_W-1:0]          arlen,
    output logic [3:0]                arid,
    input  logic                      arready,
    input  logic                      rvalid,
    input  logic [DATA_W-1:0]         rdata,
    input  logic                      rlast,
    output logic                      rready,
    output logic                      len_err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [LEN_W-1:0]   arlen_q, arlen_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    // First requesting index at or above rr_ptr, wrapping to 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(rr_ptr_q) + i >= NUM_REQ)
                cand = IDX_W'(int'(rr_ptr_q) + i - NUM_REQ);
            else
                cand = IDX_W'(int'(rr_ptr_q) + i);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        resp_last  = 1'b0;
        len_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    araddr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    arlen_d  = req_len[int'(pick_idx)*LEN_W +: LEN_W];
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    req_ready[grant_q] = 1'b1;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                rready    = 1'b1;
                resp_data = rdata;
                if (rvalid) begin
                    resp_valid[grant_q] = 1'b1;
                    if (beat_cnt_q != {(LEN_W+1){1'b1}})
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    if (rlast) begin
                        resp_last = 1'b1;
                        // Count excludes the current beat, so a correct burst ends at beat_cnt == arlen.
                        len_err   = (beat_cnt_q != {1'b0, arlen_q});
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Payload is only exposed while AR is valid so an idle channel reads as all zero.
    assign araddr = (state_q == S_ADDR) ? araddr_q : '0;
    assign arlen  = (state_q == S_ADDR) ? arlen_q : '0;
    assign arid   = (state_q == S_ADDR) ? 4'(grant_q) : 4'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR issues and R routing are queued as stimulus is driven.
module tb_axi_rd_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;

    logic                      clk = 1'b0;
    logic                      resetn = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        req_ready, resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic                      resp_last, arvalid, rready, len_err;
    logic [ADDR_W-1:0]         araddr;
    logic [LEN_W-1:0]          arlen;
    logic [3:0]                arid;
    logic                      arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [DATA_W-1:0]         rdata = '0;

    logic [ADDR_W-1:0] addr_tab [3] = '{32'h1FC0_0000, 32'h8000_1000, 32'hBFD0_0000};
    logic [LEN_W-1:0]  len_tab  [3] = '{4'd3, 4'd1, 4'd0};
    assign req_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
    assign req_len  = {len_tab[2], len_tab[1], len_tab[0]};

    axi_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arid(arid), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [3:0] len;} ar_t;
    typedef struct packed {logic [2:0] vld; logic [31:0] data; logic last; logic err;} beat_t;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    beat_t obs_beat_q[$];
    ar_t   obs_ar, ea;
    beat_t eb, ob;
    logic [2:0] obs_rdy;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rdata_of(int id, int b);
        return 32'hD000_0000 | 32'(id << 8) | 32'(b);
    endfunction

    task automatic push_burst(int id, int last_at);
        ar_t a;
        beat_t e;
        a.id = 4'(id); a.addr = addr_tab[id]; a.len = len_tab[id];
        exp_ar_q.push_back(a);
        for (int b = 0; b <= last_at; b++) begin
            e.vld  = 3'(1 << id);
            e.data = rdata_of(id, b);
            e.last = (b == last_at);
            e.err  = (b == last_at) && (b != int'(len_tab[id]));
            exp_beat_q.push_back(e);
        end
    endtask

    // Waits (bounded) for AR, optionally stalls, then handshakes and records what was issued.
    task automatic addr_phase(int wait_cyc);
        int n;
        n = 0;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arvalid) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arvalid=%b after %0d cycles, required 1", arvalid, n);
            return;
        end
        repeat (wait_cyc) @(negedge clk);
        arready = 1'b1;
        #1;
        obs_ar  = {arid, araddr, arlen};
        obs_rdy = req_ready;
        @(posedge clk);
        #1 arready = 1'b0;
    endtask

    task automatic data_phase(int id, int last_at);
        for (int b = 0; b <= last_at; b++) begin
            rvalid = 1'b1;
            rdata  = rdata_of(id, b);
            rlast  = (b == last_at);
            @(negedge clk);
            obs_beat_q.push_back({resp_valid, resp_data, resp_last, len_err});
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic reset_dut();
        resetn = 1'b0; req_valid = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if ({arvalid, rready, req_ready, resp_valid, resp_last, len_err, araddr, arlen, arid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: arvalid=%b rready=%b req_ready=%b resp_valid=%b araddr=%h arlen=%h arid=%h, required all 0",
                     arvalid, rready, req_ready, resp_valid, araddr, arlen, arid);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b0) begin
            errors++; $display("FAIL reset_no_early_ar: arvalid=%b, required 0", arvalid);
        end
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1) begin
            errors++; $display("FAIL reset_ar_latency: arvalid=%b, required 1", arvalid);
        end
        push_burst(0, 3);
        addr_phase(0);
        req_valid = '0;
        ea = exp_ar_q.pop_front();
        checks++;
        if (obs_ar !== ea) begin
            errors++; $display("FAIL reset_ar: got %h, required %h", obs_ar, ea);
        end
        data_phase(0, 3);
        while (exp_beat_q.size() > 0) begin
            eb = exp_beat_q.pop_front();
            checks++;
            if (obs_beat_q.size() == 0) begin
                errors++; $display("FAIL reset_beat: no beat captured, required %h", eb);
            end else begin
                ob = obs_beat_q.pop_front();
                if (ob !== eb) begin errors++; $display("FAIL reset_beat: got %h, required %h", ob, eb); end
            end
        end
        obs_beat_q.delete();
    endtask

    task automatic test_single();
        req_valid = 3'b001;
        push_burst(0, 3);
        addr_phase(0);
        req_valid = '0;
        ea = exp_ar_q.pop_front();
        checks++;
        if (obs_ar !== ea) begin errors++; $display("FAIL single_ar: got %h, required %h", obs_ar, ea); end
        checks++;
        if (obs_rdy !== 3'b001) begin errors++; $display("FAIL single_req_ready: got %b, required 001", obs_rdy); end
        data_phase(0, 3);
        while (exp_beat_q.size() > 0) begin
            eb = exp_beat_q.pop_front();
            checks++;
            if (obs_beat_q.size() == 0) begin
                errors++; $display("FAIL single_beat: no beat captured, required %h", eb);
            end else begin
                ob = obs_beat_q.pop_front();
                if (ob !== eb) begin errors++; $display("FAIL single_beat: got %h, required %h", ob, eb); end
            end
        end
        obs_beat_q.delete();
        @(negedge clk);
        checks++;
        if ({arvalid, rready, resp_valid, len_err} !== '0) begin
            errors++; $display("FAIL single_idle: arvalid=%b rready=%b resp_valid=%b len_err=%b, required 0",
                               arvalid, rready, resp_valid, len_err);
        end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 1, 2, 0};
        reset_dut();
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            push_burst(order[k], int'(len_tab[order[k]]));
            addr_phase(0);
            ea = exp_ar_q.pop_front();
            checks++;
            if ({obs_ar, obs_rdy} !== {ea, 3'(1 << order[k])}) begin
                errors++; $display("FAIL contention_grant%0d: ar=%h ready=%b, required ar=%h ready=%b",
                                   k, obs_ar, obs_rdy, ea, 3'(1 << order[k]));
            end
            data_phase(order[k], int'(len_tab[order[k]]));
            if (k == 3) req_valid = '0;
            while (exp_beat_q.size() > 0) begin
                eb = exp_beat_q.pop_front();
                checks++;
                if (obs_beat_q.size() == 0) begin
                    errors++; $display("FAIL contention_beat: no beat captured, required %h", eb);
                end else begin
                    ob = obs_beat_q.pop_front();
                    if (ob !== eb) begin errors++; $display("FAIL contention_beat: got %h, required %h", ob, eb); end
                end
            end
            obs_beat_q.delete();
            @(negedge clk);
            checks++;
            if (arvalid !== 1'b0) begin
                errors++; $display("FAIL contention_gap%0d: arvalid=%b one cycle after rlast, required 0", k, arvalid);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        req_valid = 3'b010;
        push_burst(1, 1);
        n = 0;
        while (!arvalid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({arvalid, araddr, arlen, req_ready} !== {1'b1, addr_tab[1], len_tab[1], 3'b000}) begin
                errors++; $display("FAIL backpressure_stable%0d: arvalid=%b araddr=%h arlen=%h req_ready=%b, required 1 %h %h 000",
                                   i, arvalid, araddr, arlen, req_ready, addr_tab[1], len_tab[1]);
            end
            @(negedge clk);
        end
        addr_phase(0);
        req_valid = '0;
        ea = exp_ar_q.pop_front();
        checks++;
        if ({obs_ar, obs_rdy} !== {ea, 3'b010}) begin
            errors++; $display("FAIL backpressure_hs: ar=%h ready=%b, required ar=%h ready=010", obs_ar, obs_rdy, ea);
        end
        data_phase(1, 1);
        while (exp_beat_q.size() > 0) begin
            eb = exp_beat_q.pop_front();
            checks++;
            if (obs_beat_q.size() == 0) begin
                errors++; $display("FAIL backpressure_beat: no beat captured, required %h", eb);
            end else begin
                ob = obs_beat_q.pop_front();
                if (ob !== eb) begin errors++; $display("FAIL backpressure_beat: got %h, required %h", ob, eb); end
            end
        end
        obs_beat_q.delete();
    endtask

    task automatic test_len_err();
        len_tab[2] = 4'd3;
        req_valid = 3'b100;
        push_burst(2, 1);
        addr_phase(0);
        req_valid = '0;
        ea = exp_ar_q.pop_front();
        checks++;
        if ({obs_ar, obs_rdy} !== {ea, 3'b100}) begin
            errors++; $display("FAIL lenerr_ar: ar=%h ready=%b, required ar=%h ready=100", obs_ar, obs_rdy, ea);
        end
        data_phase(2, 1);
        while (exp_beat_q.size() > 0) begin
            eb = exp_beat_q.pop_front();
            checks++;
            if (obs_beat_q.size() == 0) begin
                errors++; $display("FAIL lenerr_beat: no beat captured, required %h", eb);
            end else begin
                ob = obs_beat_q.pop_front();
                if (ob !== eb) begin errors++; $display("FAIL lenerr_beat: got %h, required %h", ob, eb); end
            end
        end
        obs_beat_q.delete();
        rvalid = 1'b1;
        rlast  = 1'b1;
        @(negedge clk);
        checks++;
        if ({rready, resp_valid, resp_last, len_err, arvalid} !== '0) begin
            errors++; $display("FAIL idle_rvalid_ignored: rready=%b resp_valid=%b resp_last=%b len_err=%b arvalid=%b, required 0",
                               rready, resp_valid, resp_last, len_err, arvalid);
        end
        @(posedge clk);
        #1 rvalid = 1'b0;
        rlast = 1'b0;
        len_tab[2] = 4'd0;
    endtask

    task automatic test_mid_reset();
        len_tab[1] = 4'd3;
        req_valid = 3'b010;
        addr_phase(0);
        req_valid = '0;
        checks++;
        if ({obs_ar.id, obs_rdy} !== {4'd1, 3'b010}) begin
            errors++; $display("FAIL midreset_grant: arid=%h ready=%b, required 1 010", obs_ar.id, obs_rdy);
        end
        rvalid = 1'b1;
        rdata  = rdata_of(1, 0);
        @(negedge clk);
        checks++;
        if ({resp_valid, resp_data} !== {3'b010, rdata_of(1, 0)}) begin
            errors++; $display("FAIL midreset_beat0: resp_valid=%b data=%h, required 010 %h", resp_valid, resp_data, rdata_of(1, 0));
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rready, resp_valid, resp_last, len_err, arvalid, req_ready} !== '0) begin
            errors++; $display("FAIL midreset_outputs: rready=%b resp_valid=%b arvalid=%b, required 0", rready, resp_valid, arvalid);
        end
        @(posedge clk);
        #1 rvalid = 1'b0;
        resetn = 1'b1;
        len_tab[1] = 4'd1;
        req_valid = 3'b111;
        push_burst(0, 3);
        addr_phase(0);
        req_valid = '0;
        ea = exp_ar_q.pop_front();
        checks++;
        if ({obs_ar, obs_rdy} !== {ea, 3'b001}) begin
            errors++; $display("FAIL midreset_rrptr: ar=%h ready=%b, required ar=%h ready=001", obs_ar, obs_rdy, ea);
        end
        data_phase(0, 3);
        while (exp_beat_q.size() > 0) begin
            eb = exp_beat_q.pop_front();
            checks++;
            if (obs_beat_q.size() == 0) begin
                errors++; $display("FAIL midreset_beat: no beat captured, required %h", eb);
            end else begin
                ob = obs_beat_q.pop_front();
                if (ob !== eb) begin errors++; $display("FAIL midreset_beat: got %h, required %h", ob, eb); end
            end
        end
        obs_beat_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_len_err();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
